// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the six-digit display scan controller.
package disp_scan_ctrl_pkg;

  localparam logic [1:0] FLD_HOUR = 2'd2;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd0;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;

  localparam logic [3:0] DIG_ERR = 4'hE;
  localparam logic [3:0] DIG_OVF = 4'hF;

  typedef enum logic [1:0] {
    ST_LOAD_H,
    ST_LOAD_M,
    ST_LOAD_S,
    ST_SCAN
  } scan_state_t;

  // Digit index 5..0 maps pairwise onto the hour/minute/second fields.
  function automatic logic [1:0] field_of(input logic [2:0] idx);
    return idx[2:1];
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_split.sv
// Combinational binary-to-tens/ones splitter, shared by all three field loads.
module digit_split
  import disp_scan_ctrl_pkg::*;
(
  input  logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    tens = 4'(value / 7'd10);
    ones = 4'(value % 7'd10);
    if (value > 7'd99) begin
      tens = DIG_OVF;
      ones = DIG_OVF;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Six-digit multiplexed display scanner: snapshots H/M/S once per frame, then
// walks the digits with one-hot select, BCD value, blink and error blanking.
//
// state     | meaning
// ST_LOAD_H | capture hour digits and blink mask, outputs dark
// ST_LOAD_M | capture minute digits, outputs dark
// ST_LOAD_S | capture second digits, arm scan counter
// ST_SCAN   | present digits 5..0, SCAN_DIV cycles each
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] HOUR,
  input  logic [6:0] MIN,
  input  logic [6:0] SEC,
  input  logic [2:0] BLINK_MASK,
  output logic [5:0] DIGIT_SEL,
  output logic [3:0] DIGIT_VAL,
  output logic       DIGIT_BLANK,
  output logic       FRAME_DONE
);

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

  scan_state_t state;
  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic [3:0]  digits [6];
  logic [2:0]  mask_q;
  logic [7:0]  frame_cnt;
  logic        blink_phase;

  logic [1:0]  fld;
  logic [6:0]  split_in;
  logic [6:0]  limit;
  logic [3:0]  split_tens, split_ones;
  logic [3:0]  cap_tens, cap_ones;

  always_comb begin
    fld = FLD_HOUR;
    case (state)
      ST_LOAD_M: fld = FLD_MIN;
      ST_LOAD_S: fld = FLD_SEC;
      default:   fld = FLD_HOUR;
    endcase
  end

  always_comb begin
    split_in = HOUR;
    limit    = HOUR_MAX;
    case (fld)
      FLD_MIN: begin
        split_in = MIN;
        limit    = MIN_MAX;
      end
      FLD_SEC: begin
        split_in = SEC;
        limit    = SEC_MAX;
      end
      default: begin
        split_in = HOUR;
        limit    = HOUR_MAX;
      end
    endcase
  end

  digit_split u_split (
    .value (split_in),
    .tens  (split_tens),
    .ones  (split_ones)
  );

  // Out-of-range fields show the error dash on both of their digits.
  assign cap_tens = (split_in > limit) ? DIG_ERR : split_tens;
  assign cap_ones = (split_in > limit) ? DIG_ERR : split_ones;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_LOAD_H;
      scan_cnt    <= SCAN_LAST;
      digit_idx   <= 3'd5;
      for (int i = 0; i < 6; i++) digits[i] <= 4'h0;
      mask_q      <= 3'b000;
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b0;
      DIGIT_SEL   <= 6'b0;
      DIGIT_VAL   <= 4'h0;
      DIGIT_BLANK <= 1'b1;
      FRAME_DONE  <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;

      if (FRAME_DONE) begin
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt   <= 8'd0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end

      case (state)
        ST_LOAD_H, ST_LOAD_M, ST_LOAD_S: begin
          digits[{fld, 1'b1}] <= cap_tens;
          digits[{fld, 1'b0}] <= cap_ones;
          DIGIT_SEL   <= 6'b0;
          DIGIT_BLANK <= 1'b1;
          if (state == ST_LOAD_H) begin
            mask_q <= BLINK_MASK;
            state  <= ST_LOAD_M;
          end else if (state == ST_LOAD_M) begin
            state <= ST_LOAD_S;
          end else begin
            scan_cnt  <= SCAN_LAST;
            digit_idx <= 3'd5;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          DIGIT_SEL   <= 6'd1 << digit_idx;
          DIGIT_VAL   <= digits[digit_idx];
          DIGIT_BLANK <= blink_phase & mask_q[field_of(digit_idx)];
          if (scan_cnt == 16'd0) begin
            scan_cnt <= SCAN_LAST;
            if (digit_idx == 3'd0) begin
              FRAME_DONE <= 1'b1;
              state      <= ST_LOAD_H;
            end else begin
              digit_idx <= digit_idx - 3'd1;
            end
          end else begin
            scan_cnt <= scan_cnt - 16'd1;
          end
        end
        default: state <= ST_LOAD_H;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed-vector bench for disp_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_disp_scan_ctrl;

  localparam int DIV = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [6:0] HOUR = 7'd0, MIN = 7'd0, SEC = 7'd0;
  logic [2:0] BLINK_MASK = 3'b000;
  logic [5:0] DIGIT_SEL;
  logic [3:0] DIGIT_VAL;
  logic       DIGIT_BLANK;
  logic       FRAME_DONE;

  int n_vec = 0;
  int n_err = 0;

  disp_scan_ctrl #(.SCAN_DIV(DIV), .BLINK_FRAMES(2)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .HOUR        (HOUR),
    .MIN         (MIN),
    .SEC         (SEC),
    .BLINK_MASK  (BLINK_MASK),
    .DIGIT_SEL   (DIGIT_SEL),
    .DIGIT_VAL   (DIGIT_VAL),
    .DIGIT_BLANK (DIGIT_BLANK),
    .FRAME_DONE  (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_val({tag, ".sel"},   32'(DIGIT_SEL),   32'h0);
    chk_val({tag, ".val"},   32'(DIGIT_VAL),   32'h0);
    chk_val({tag, ".blank"}, 32'(DIGIT_BLANK), 32'h1);
    chk_val({tag, ".fd"},    32'(FRAME_DONE),  32'h0);
  endtask

  // Called just after an edge with the DUT about to execute LOAD_H on the next one.
  // vals: digit5 in [23:20] .. digit0 in [3:0]; blank: per-digit expected blanking.
  task automatic check_frame(input string name, input logic [23:0] vals,
                             input logic [5:0] blank, input int chg_at,
                             input logic [6:0] chg_min);
    int k;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_val($sformatf("%s.load%0d.sel", name, i),   32'(DIGIT_SEL),   32'h0);
      chk_val($sformatf("%s.load%0d.blank", name, i), 32'(DIGIT_BLANK), 32'h1);
      chk_val($sformatf("%s.load%0d.fd", name, i),    32'(FRAME_DONE),  32'h0);
      k++;
    end
    for (int d = 5; d >= 0; d--) begin
      for (int c = 0; c < DIV; c++) begin
        logic [5:0] esel;
        tick();
        esel = 6'd1 << d;
        chk_val($sformatf("%s.t%0d.sel", name, k),   32'(DIGIT_SEL),   32'(esel));
        chk_val($sformatf("%s.t%0d.val", name, k),   32'(DIGIT_VAL),   32'(vals[d*4 +: 4]));
        chk_val($sformatf("%s.t%0d.blank", name, k), 32'(DIGIT_BLANK), 32'(blank[d]));
        chk_val($sformatf("%s.t%0d.fd", name, k),    32'(FRAME_DONE),
                32'((d == 0 && c == DIV - 1) ? 1 : 0));
        if (k == chg_at) MIN = chg_min;
        k++;
      end
    end
  endtask

  initial begin
    int fd_seen;
    HOUR = 7'd13; MIN = 7'd45; SEC = 7'd7;
    fd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (FRAME_DONE) fd_seen++;
    end
    chk_reset_outs("reset_hold");
    chk_val("reset_hold.no_fd", 32'(fd_seen), 32'h0);

    RESET = 1'b0;
    // Basic frame plus snapshot coherency: MIN changes at t10, visible next frame.
    check_frame("basic",    24'h134507, 6'b0, 10, 7'd46);
    check_frame("snap_next", 24'h134607, 6'b0, -1, 7'd0);

    HOUR = 7'd24; MIN = 7'd0; SEC = 7'd60;
    check_frame("range", 24'hEE00EE, 6'b0, -1, 7'd0);
    HOUR = 7'd0; MIN = 7'd59; SEC = 7'd0;
    check_frame("bound_lo", 24'h005900, 6'b0, -1, 7'd0);
    HOUR = 7'd23; MIN = 7'd59; SEC = 7'd59;
    check_frame("bound_hi", 24'h235959, 6'b0, -1, 7'd0);
    HOUR = 7'd127; MIN = 7'd60; SEC = 7'd99;
    check_frame("range_max", 24'hEEEEEE, 6'b0, -1, 7'd0);

    // Reset mid-frame while digit 2 is shown.
    HOUR = 7'd12; MIN = 7'd34; SEC = 7'd56; BLINK_MASK = 3'b010;
    for (int i = 0; i < 3 + 3 * DIV + 1; i++) tick();
    chk_val("midrst.pre_sel", 32'(DIGIT_SEL), 32'h04);
    RESET = 1'b1;
    tick();
    chk_reset_outs("midrst.t1");
    fd_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (FRAME_DONE) fd_seen++;
    end
    chk_reset_outs("midrst.held");
    chk_val("midrst.no_fd", 32'(fd_seen), 32'h0);
    RESET = 1'b0;

    // Blink counter restarted by reset: phase 0,0,1,1,0,0 across frames.
    check_frame("blink0", 24'h123456, 6'b000000, -1, 7'd0);
    check_frame("blink1", 24'h123456, 6'b000000, -1, 7'd0);
    BLINK_MASK = 3'b000;
    check_frame("blink2_maskq", 24'h123456, 6'b000000, -1, 7'd0);
    BLINK_MASK = 3'b010;
    check_frame("blink3", 24'h123456, 6'b001100, -1, 7'd0);
    check_frame("blink4", 24'h123456, 6'b000000, -1, 7'd0);
    check_frame("blink5", 24'h123456, 6'b000000, -1, 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
